sad_min_select: RTL
===================

Name: sad_min_select

Overview:
- Downstream stage of the pipelined SAD datapath. Consumes the stream of per-candidate SAD results and finds the lowest SAD (the best match) across one search window of N_CAND candidates.
- Reports the best SAD value and the index of the candidate that produced it, then holds the result under a valid/ack handshake until the motion-estimation controller takes it.

Parameters:
- WIDTH, 8, pixel width of the SAD datapath; SAD values are WIDTH+5 bits.
- N_CAND, 16, number of candidates per search window; must be ≥ 2.
- IDX_W, 8, width of the candidate index; N_CAND ≤ 2^IDX_W.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begins a new search window; sampled in IDLE, or in HOLD together with res_ack.
- sad_in  in  WIDTH+5  SAD value of the current candidate (out_sad of the SAD stage).
- sad_valid  in  1  sad_in carries a valid result this cycle.
- sad_ready  out  1  block accepts sad_in this cycle; high only in SCAN.
- best_sad  out  WIDTH+5  minimum SAD of the window; meaningful only while res_valid is high.
- best_idx  out  IDX_W  zero-based arrival order of the winning candidate.
- res_valid  out  1  result available; high throughout HOLD.
- res_ack  in  1  consumer takes the result.
- busy  out  1  high in SCAN.

Behaviour:
- Reset: on a rising edge with rst=1 → state IDLE, best_sad=0, best_idx=0, internal count=0, res_valid=0, sad_ready=0, busy=0. rst has priority over all other inputs. Reset mid-SCAN or mid-HOLD discards the window entirely.
- Outputs: all are registered or decoded directly from the state register. No combinational path from any input to any output.
- Accept condition: a sample is accepted when sad_valid && sad_ready. Cycles with sad_valid=0 are bubbles; they change nothing and do not advance count.
- State IDLE:
  - sad_ready=0; sad_valid is ignored.
  - start=1 → SCAN, count=0, best_sad=all-ones, best_idx=0.
- State SCAN:
  - sad_ready=1, busy=1.
  - On each accept: if sad_in < best_sad (strict, unsigned), then best_sad←sad_in and best_idx←count. count←count+1.
  - Ties keep the earlier index.
  - An input equal to all-ones never updates, so index 0 and the all-ones value stand if every sample is all-ones.
  - When the accepted sample is number N_CAND-1 (count==N_CAND-1): apply the final compare in the same edge, go to HOLD, and clear count.
  - start is ignored in SCAN.
- State HOLD:
  - res_valid=1, sad_ready=0. best_sad and best_idx are stable.
  - res_valid rises on the edge that accepts the last sample, so it is visible the cycle after that accept (latency 1).
  - res_ack=1 and start=0 → IDLE.
  - res_ack=1 and start=1 → SCAN directly, with the same reinitialisation as IDLE→SCAN. res_valid drops the following cycle.
  - res_ack=0 → remain in HOLD indefinitely; sad_valid is ignored (no sample is lost, because sad_ready=0).
- Width: count is IDX_W bits and never wraps inside a window, because N_CAND ≤ 2^IDX_W.
- Throughput: one sample per cycle in SCAN. Back-to-back windows cost 1 cycle of HOLD when res_ack is held high together with start.

Test Plan (N_CAND=4, WIDTH=8, IDX_W=8):
1. Basic minimum: reset, start, then sad_in 100,40,70,90 on consecutive cycles with sad_valid=1 → the cycle after the 4th accept: res_valid=1, best_sad=40, best_idx=1, sad_ready=0.
2. Ties and bubbles: sad_in 50,20,20,30 with sad_valid low for 2 cycles between the 2nd and 3rd samples → best_sad=20, best_idx=1. res_valid rises only after the 4th accepted sample; busy stays high during the bubbles.
3. Extremes: all four samples 8191 (all-ones) → best_sad=8191, best_idx=0. Next window 8191,8191,8191,0 → best_sad=0, best_idx=3.
4. Hold/handshake:
   - Hold res_ack=0 for 10 cycles while toggling sad_valid → outputs stable, sad_ready=0, res_valid=1.
   - res_ack=1 with start=0 → IDLE next cycle.
   - Second run: res_ack=1 with start=1 → SCAN next cycle, and a new window 9,8,7,6 yields best_sad=6, best_idx=3.
5. Reset mid-operation: start, accept 5 and 3, assert rst for 1 cycle → all outputs return to reset values. Then start with 60,70,80,65 → best_sad=60, best_idx=0, with no influence from the earlier samples.
6. start ignored in SCAN: pulse start after 2 accepted samples of 30,10,40,20 → count is not cleared; result best_sad=10, best_idx=1 after exactly 4 accepts.

Source files
------------

// File: rtl/sad_min_select.sv
// Minimum-SAD selector: scans N_CAND SAD results, keeps the lowest value and
// its arrival index, then holds the result under a valid/ack handshake.
module sad_min_select #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned N_CAND = 16,
    parameter int unsigned IDX_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH+4:0] sad_in,
    input  logic             sad_valid,
    output logic             sad_ready,
    output logic [WIDTH+4:0] best_sad,
    output logic [IDX_W-1:0] best_idx,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] count;
    logic             accept;
    logic             last;
    logic             init;

    assign accept = (state == SCAN) && sad_valid;
    assign last   = accept && (count == IDX_W'(N_CAND - 1));

    always_comb begin
        state_nx = state;
        init     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SCAN;
                    init     = 1'b1;
                end
            end
            SCAN: begin
                if (last) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                // ack together with start chains straight into the next window
                if (res_ack) begin
                    if (start) begin
                        state_nx = SCAN;
                        init     = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            best_sad <= '0;
            best_idx <= '0;
        end else if (init) begin
            count    <= '0;
            best_sad <= '1;
            best_idx <= '0;
        end else if (accept) begin
            // strict compare keeps the earlier index on ties
            if (sad_in < best_sad) begin
                best_sad <= sad_in;
                best_idx <= count;
            end
            count <= last ? '0 : count + IDX_W'(1);
        end
    end

    assign sad_ready = (state == SCAN);
    assign busy      = (state == SCAN);
    assign res_valid = (state == HOLD);

endmodule
